count_compare_irq: RTL

// - Downstream consumer of the user-project counter value; lives beside the counter in the user area.
// - Holds two Wishbone-programmable compare registers and detects when the incoming count hits either.
// - Detects wrap of the count from all-ones to zero.
// - Latches sticky status flags and drives maskable interrupt lines and one-cycle match pulses for GPIO/LA.

---
 rtl/count_compare_irq.sv | 137 +++++++++++++
 1 files changed

// File: rtl/count_compare_irq.sv
// count_compare_irq
// Watches an upstream counter value and flags when it hits either of two
// Wishbone-programmable compare values, or wraps from all-ones to zero.
// Sticky status flags drive two maskable level interrupts; each compare also
// gives a one-cycle pulse for GPIO/LA observation.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset (also the Wishbone side)
//   wbs_cyc_i/stb_i   Wishbone cycle/strobe
//   wbs_we_i          write enable
//   wbs_sel_i[3:0]    byte lane selects
//   wbs_adr_i[31:0]   byte address, [3:2] picks CMP0/CMP1/CTRL/STATUS
//   wbs_dat_i[31:0]   write data
//   wbs_ack_o         registered one-cycle acknowledge
//   wbs_dat_o[31:0]   registered read data, zero-extended above BITS
//   count[BITS-1:0]   current counter value
//   cmp_pulse[1:0]    one-cycle pulse per compare match
//   irq[1:0]          [0] compare irq, [1] wrap irq (level)
module count_compare_irq #(
  parameter int unsigned BITS      = 16,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0100
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic [BITS-1:0] count,
  output logic [1:0]      cmp_pulse,
  output logic [1:0]      irq
);

  logic [BITS-1:0] cmp0_q, cmp0_d;
  logic [BITS-1:0] cmp1_q, cmp1_d;
  logic [BITS-1:0] count_prev_q;
  logic [4:0]      ctrl_q, ctrl_d;
  logic [2:0]      status_q, status_d;
  logic            ack_q;
  logic [31:0]     dat_q, dat_d;
  logic [1:0]      pulse_q;

  logic            sel;
  logic            access;
  logic            wr_en;
  logic            rd_en;
  logic [1:0]      reg_idx;
  logic [31:0]     byte_mask;
  logic [BITS-1:0] wmask;
  logic [2:0]      status_clr;
  logic [1:0]      match;
  logic            wrap_ev;
  logic [31:0]     rdata;

  assign sel     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  // A transfer is taken only on the cycle ack rises; this gives ack every other
  // cycle for back-to-back requests and makes the write commit on that edge.
  assign access  = sel & ~ack_q;
  assign wr_en   = access & wbs_we_i;
  assign rd_en   = access & ~wbs_we_i;
  assign reg_idx = wbs_adr_i[3:2];

  assign byte_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign wmask     = byte_mask[BITS-1:0];

  // Event detection. Requiring a change in count keeps a held value from re-firing.
  assign match[0] = ctrl_q[0] & (count == cmp0_q) & (count != count_prev_q);
  assign match[1] = ctrl_q[1] & (count == cmp1_q) & (count != count_prev_q);
  assign wrap_ev  = (count_prev_q == {BITS{1'b1}}) & (count == '0);

  always_comb begin
    rdata = '0;
    unique case (reg_idx)
      2'd0:    rdata = 32'(cmp0_q);
      2'd1:    rdata = 32'(cmp1_q);
      2'd2:    rdata = {27'd0, ctrl_q};
      default: rdata = {29'd0, status_q};
    endcase
  end

  always_comb begin
    cmp0_d     = cmp0_q;
    cmp1_d     = cmp1_q;
    ctrl_d     = ctrl_q;
    status_clr = '0;
    dat_d      = dat_q;
    if (wr_en) begin
      unique case (reg_idx)
        2'd0:    cmp0_d = (cmp0_q & ~wmask) | (wbs_dat_i[BITS-1:0] & wmask);
        2'd1:    cmp1_d = (cmp1_q & ~wmask) | (wbs_dat_i[BITS-1:0] & wmask);
        2'd2:    if (wbs_sel_i[0]) ctrl_d = wbs_dat_i[4:0];
        default: if (wbs_sel_i[0]) status_clr = wbs_dat_i[2:0];
      endcase
    end
    if (rd_en) begin
      dat_d = rdata;
    end
    // Set after clear so a simultaneous event wins over W1C.
    status_d = (status_q & ~status_clr) | {wrap_ev, match};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmp0_q       <= '0;
      cmp1_q       <= '0;
      ctrl_q       <= '0;
      status_q     <= '0;
      count_prev_q <= '0;
      ack_q        <= 1'b0;
      dat_q        <= '0;
      pulse_q      <= '0;
    end else begin
      cmp0_q       <= cmp0_d;
      cmp1_q       <= cmp1_d;
      ctrl_q       <= ctrl_d;
      status_q     <= status_d;
      count_prev_q <= count;
      ack_q        <= access;
      dat_q        <= dat_d;
      pulse_q      <= match;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign cmp_pulse = pulse_q;
  assign irq[0]    = (status_q[0] & ctrl_q[2]) | (status_q[1] & ctrl_q[3]);
  assign irq[1]    = status_q[2] & ctrl_q[4];

  logic unused_bits;
  assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i, byte_mask};

endmodule
